// File: rtl/button_pio_pkg.sv
// Shared constants for the button/switch PIO: register addresses,
// edge-mode encodings and debounce counter sizing.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

  typedef enum logic [1:0] {
    EM_RISING   = 2'b00,
    EM_FALLING  = 2'b01,
    EM_EITHER   = 2'b10,
    EM_DISABLED = 2'b11
  } edge_mode_e;

  // Counter must hold the value DEBOUNCE_CYCLES itself, so it can never wrap.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_pio_debounce.sv
// Single-bit input conditioner: 2-flop synchronizer followed by a
// consecutive-difference counter that toggles the debounced output.
module button_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_db
);
  import button_pio_pkg::*;

  logic r_sync1;
  logic r_sync2;
  logic r_db;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_db <= 1'b0;
        else          r_db <= r_sync2;
      end
    end else begin : g_filter
      localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

      logic [CW-1:0] r_cnt;

      // Toggle happens on the edge after the count reaches CNT_MAX, giving
      // a total latency of 3 + DEBOUNCE_CYCLES from the pin.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt <= '0;
          r_db  <= ~r_db;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign o_db = r_db;

endmodule

// File: rtl/button_pio.sv
// Avalon-MM input PIO for keys/switches: debounced data register, edge
// capture with selectable edge type, and a masked level interrupt.
module button_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);
  import button_pio_pkg::*;

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  logic [WIDTH-1:0] r_db_prev;
  edge_mode_e       r_edge_mode;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      button_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_in    (in_port[i]),
        .o_db    (w_db[i])
      );
    end
  endgenerate

  assign w_wr = chipselect & ~write_n;

  always_comb begin
    w_rise = w_db & ~r_db_prev;
    w_fall = ~w_db & r_db_prev;
    unique case (r_edge_mode)
      EM_RISING:   w_set = w_rise;
      EM_FALLING:  w_set = w_fall;
      EM_EITHER:   w_set = w_rise | w_fall;
      default:     w_set = '0;
    endcase
    w_clr = (w_wr && address == ADDR_EDGE_CAP) ? writedata : '0;
  end

  // Clear is applied before set so a simultaneous new edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_prev   <= '0;
      r_edge_mode <= EM_RISING;
      r_irq_mask  <= '0;
      r_edge_cap  <= '0;
    end else begin
      r_db_prev <= w_db;
      if (w_wr && address == ADDR_EDGE_MODE) r_edge_mode <= edge_mode_e'(writedata[1:0]);
      if (w_wr && address == ADDR_IRQ_MASK)  r_irq_mask  <= writedata;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:      readdata = w_db;
      ADDR_EDGE_MODE: readdata[1:0] = r_edge_mode;
      ADDR_IRQ_MASK:  readdata = r_irq_mask;
      default:        readdata = r_edge_cap;
    endcase
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: doc/button_pio.md
BUTTON_PIO -- requirements
Module: button_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of input bits (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable clocks needed to accept a change (0 = bypass).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  2  Avalon-MM register select.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  WIDTH  write data.
REQ-009 SHALL have port in_port  input  WIDTH  asynchronous external inputs (keys/switches).
REQ-010 SHALL have port readdata  output  WIDTH  read data, zero wait states, combinational from address.
REQ-011 SHALL have port irq  output  1  level interrupt, active high.

Function
REQ-012 Register map SHALL be: 0 data (RO, debounced value); 1 edge_mode (RW, bits [1:0]); 2 irq_mask (RW, WIDTH bits); 3 edge_capture (RO, write-1-to-clear).
REQ-013 Write SHALL occur when chipselect=1 and write_n=0; writes to address 0 are ignored.
REQ-014 readdata SHALL be the addressed register, upper bits zero-filled for edge_mode; read has no side effects.
REQ-015 Each in_port bit SHALL pass a 2-flop synchronizer before any other use.
REQ-016 Debounce per bit: counter increments each clock the synchronized bit differs from the debounced bit, clears to 0 when equal; when the count reaches DEBOUNCE_CYCLES the debounced bit toggles and the counter clears.
REQ-017 A pulse shorter than DEBOUNCE_CYCLES clocks SHALL NOT change the debounced bit.
REQ-018 DEBOUNCE_CYCLES=0: debounced bit SHALL be a register copy of the synchronized bit.
REQ-019 Latency from a stable in_port change to the data register SHALL be 3 + DEBOUNCE_CYCLES rising edges.
REQ-020 edge_mode: 00 rising, 01 falling, 10 either, 11 capture disabled.
REQ-021 An edge_capture bit SHALL set on the clock after its debounced bit transitions with a matching edge_mode, and hold until cleared.
REQ-022 Same-cycle set and write-1-clear of one bit: set SHALL win.
REQ-023 Writing 0 to an edge_capture bit SHALL leave it unchanged.
REQ-024 irq SHALL be combinational OR-reduction of (edge_capture AND irq_mask).
REQ-025 Counter width SHALL be sized from DEBOUNCE_CYCLES with no wrap-around possible.

Reset
REQ-026 On reset_n=0, synchronizers, debounced bits, counters, irq_mask and edge_capture SHALL clear to 0 immediately; edge_mode SHALL reset to 00.
REQ-027 irq SHALL be 0 during and immediately after reset.
REQ-028 After reset release with an input held high, the debounced 0->1 transition SHALL set edge_capture (irq stays low since mask=0).
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-030 Package button_pio_pkg SHALL hold address constants (ADDR_DATA, ADDR_EDGE_MODE, ADDR_IRQ_MASK, ADDR_EDGE_CAP) and edge-mode encodings.
REQ-031 One sub-module button_pio_debounce (single bit: synchronizer, counter, debounced output) SHALL be instantiated WIDTH times.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-032 in_port 0000->0001 held -> data reads 0001 exactly 7 edges later; edge_capture=0001.
REQ-033 in_port[2] high for 3 clocks only -> data and edge_capture unchanged.
REQ-034 edge_mode=01, irq_mask=0010, in_port[1] 1->0 -> edge_capture[1]=1, irq=1; write 0010 to addr 3 -> irq=0.
REQ-035 Edge on bit 0 in same cycle as write 0001 to addr 3 -> edge_capture[0] stays 1.
REQ-036 edge_mode=11, toggle all inputs -> edge_capture stays 0000, data tracks inputs.
REQ-037 Assert reset_n mid-debounce with irq=1 -> irq, edge_capture, irq_mask read 0 immediately; edge_mode reads 00.
